// File: rtl/pipe_step_pkg.sv
// Shared types and board defaults for the pipeline single-step / free-run clock-enable source.
package pipe_step_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 50 MHz board: 10 ms debounce, 2 steps per second in run mode
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_RUN_DIV         = 25000000;
  localparam int unsigned DEF_CNT_W           = 32;

endpackage

// File: rtl/pipe_step_ctrl_sync_2ff.sv
// 1-bit two-flop synchronizer; next_o exposes the first stage so callers can see a change one edge early.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic next_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o    = s2_q;
  assign next_o = s1_q;

endmodule

// File: rtl/pipe_step_ctrl.sv
// Pipeline clock-enable source: debounced push-button single step or divider-driven free run,
// with a wrapping count of issued steps.
module pipe_step_ctrl
  import pipe_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_n,
  input  logic             run_mode,
  output logic             step_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       btn_state
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic btn_sync, btn_next_unused;
  logic run_s, run_next;
  logic pressed_s, run_chg;

  sync_2ff #(.RESET_VAL(1'b1)) u_btn_sync (
    .clock  (clock),
    .reset  (reset),
    .d_i    (btn_n),
    .q_o    (btn_sync),
    .next_o (btn_next_unused)
  );

  sync_2ff #(.RESET_VAL(1'b0)) u_run_sync (
    .clock  (clock),
    .reset  (reset),
    .d_i    (run_mode),
    .q_o    (run_s),
    .next_o (run_next)
  );

  assign pressed_s = ~btn_sync;
  // run_s takes run_next on this edge, so a mismatch marks the edge on which run_s changes
  assign run_chg   = run_next ^ run_s;

  btn_state_e       state_q, state_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             btn_req, div_req, step_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          btn_req = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d   = '0;
    div_req = 1'b0;
    if (!run_chg && run_s) begin
      if (div_q == DIV_LAST) begin
        div_req = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Button requests still advance the FSM in run mode but never reach step_en
  always_comb begin
    step_req = run_s ? div_req : btn_req;
    step_d   = step_req & ~step_q;
    count_d  = count_q + CNT_W'(step_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      step_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      step_q  <= step_d;
      count_q <= count_d;
    end
  end

  assign step_en     = step_q;
  assign cycle_count = count_q;
  assign btn_state   = state_q;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Bench for pipe_step_ctrl: run-length debounce model and edge-anchored divider model, directed + random.
module tb_pipe_step_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 5;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          btn_n = 1'b1;
  logic          run_mode = 1'b0;
  logic          step_en;
  logic [CW-1:0] cycle_count;
  logic [1:0]    btn_state;

  always #5 clock = ~clock;

  pipe_step_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .RUN_DIV         (RD),
    .CNT_W           (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_n       (btn_n),
    .run_mode    (run_mode),
    .step_en     (step_en),
    .cycle_count (cycle_count),
    .btn_state   (btn_state)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          edge_no = 0;
  bit          model_valid = 1'b0;

  // Model: input delay lines, press/release run lengths, divider anchor edge
  bit         b1, b2, r1, r2, armed;
  int         prun, rrun, anchor, m_cnt;
  bit         m_step;
  logic [1:0] m_state;
  bit         mp, mrs, mchg, bfire, dfire, mreq;
  int         pulse_log[$];

  initial forever begin
    @(posedge clock);
    edge_no++;
    if (reset) begin
      b1 = 1'b1; b2 = 1'b1; r1 = 1'b0; r2 = 1'b0;
      armed = 1'b1; prun = 0; rrun = 0; anchor = edge_no;
      m_step = 1'b0; m_cnt = 0; model_valid = 1'b1;
    end else if (model_valid) begin
      mp   = !b2;
      mrs  = r2;
      mchg = (r1 != r2);
      if (mp) begin prun++; rrun = 0; end
      else    begin rrun++; prun = 0; end
      bfire = 1'b0;
      if (armed && prun == DB + 1) begin
        bfire = 1'b1;
        armed = 1'b0;
      end else if (!armed && rrun == DB + 1) begin
        armed = 1'b1;
      end
      if (mchg) anchor = edge_no;
      dfire = mrs && !mchg && ((edge_no - anchor) % RD == 0);
      mreq  = mrs ? dfire : bfire;
      m_cnt = (m_cnt + int'(m_step)) % (1 << CW);
      m_step = mreq && !m_step;
      b2 = b1; b1 = btn_n;
      r2 = r1; r1 = run_mode;
    end
    if (armed) m_state = (prun == 0) ? 2'd0 : 2'd1;
    else       m_state = (rrun == 0) ? 2'd2 : 2'd3;
  end

  initial forever begin
    @(negedge clock);
    if (model_valid) begin
      vectors++;
      if (step_en !== m_step || cycle_count !== m_cnt[CW-1:0] || btn_state !== m_state) begin
        miscompares++;
        $display("FAIL cycle after edge %0d: step_en=%b cycle_count=%0d btn_state=%0d, required %b %0d %0d",
                 edge_no, step_en, cycle_count, btn_state, m_step, m_cnt[CW-1:0], m_state);
      end
      if (step_en === 1'b1) pulse_log.push_back(edge_no);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic goto_edge(input int e);
    while (edge_no < e) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_n = 1'b1; run_mode = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    pulse_log.delete();
  endtask

  int base, b0, left;

  initial begin
    @(negedge clock);
    // Reset
    do_reset();
    check("reset_step_en", step_en, 0);
    check("reset_count", cycle_count, 0);
    check("reset_state", btn_state, 0);

    // Clean press first sampled at base+10
    do_reset(); base = edge_no;
    goto_edge(base + 9);  btn_n = 1'b0;
    goto_edge(base + 29); btn_n = 1'b1;
    goto_edge(base + 45);
    check("clean_npulses", pulse_log.size(), 1);
    check("clean_pulse_edge", (pulse_log.size() > 0) ? pulse_log[0] - base : -1, 16);
    check("clean_count", cycle_count, 1);

    // Bounce, then steady low from base+20
    do_reset(); base = edge_no;
    goto_edge(base + 13); btn_n = 1'b0;
    goto_edge(base + 15); btn_n = 1'b1;
    goto_edge(base + 16); btn_n = 1'b0;
    goto_edge(base + 18); btn_n = 1'b1;
    goto_edge(base + 19); btn_n = 1'b0;
    goto_edge(base + 35); btn_n = 1'b1;
    goto_edge(base + 50);
    check("bounce_npulses", pulse_log.size(), 1);
    check("bounce_pulse_edge", (pulse_log.size() > 0) ? pulse_log[0] - base : -1, 26);

    // Long hold with a short glitch, then a second press
    do_reset(); base = edge_no;
    goto_edge(base + 1);   btn_n = 1'b0;
    goto_edge(base + 51);  btn_n = 1'b1;
    goto_edge(base + 53);  btn_n = 1'b0;
    goto_edge(base + 101); btn_n = 1'b1;
    goto_edge(base + 121); btn_n = 1'b0;
    goto_edge(base + 141); btn_n = 1'b1;
    goto_edge(base + 160);
    check("hold_npulses", pulse_log.size(), 2);
    check("hold_count", cycle_count, 2);

    // Run mode with the button held
    do_reset(); b0 = edge_no + 1;
    btn_n = 1'b0; run_mode = 1'b1;
    goto_edge(b0 + 22);
    check("run_count", cycle_count, 4);
    run_mode = 1'b0;
    goto_edge(b0 + 60);
    check("run_npulses", pulse_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check("run_pulse_edge", (pulse_log.size() > i) ? pulse_log[i] - b0 : -1, 6 + 5 * i);
    check("run_exit_state", btn_state, 2);
    btn_n = 1'b1;

    // Reset during PRESS_WAIT, then wrap the counter in run mode
    do_reset(); base = edge_no;
    btn_n = 1'b0;
    goto_edge(base + 5);
    check("pw_state_before_reset", btn_state, 1);
    reset = 1'b1; btn_n = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("abort_state", btn_state, 0);
    base = edge_no;
    goto_edge(base + 20);
    check("abort_npulses", pulse_log.size(), 0);
    b0 = edge_no + 1; run_mode = 1'b1;
    goto_edge(b0 + 82);
    check("wrap_count", cycle_count, 0);
    check("wrap_npulses", pulse_log.size(), 16);
    run_mode = 1'b0;
    goto_edge(b0 + 90);

    // Random bursts, mode flips and occasional resets
    do_reset();
    left = 0;
    repeat (3000) begin
      @(negedge clock);
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 149) == 0) run_mode = ~run_mode;
      if (left == 0) begin
        btn_n = ~btn_n;
        left = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
      end else begin
        left--;
      end
    end
    reset = 1'b0;
    repeat (5) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, required completion before 2000000");
    $fatal(1);
  end

endmodule
